// File: rtl/df_stream_pkg.sv
// Shared constants, FSM encoding and the per-neuron stride helper for df_stream.
// Defining DF_BIAS_FETCH_EN widens the stride by one bias word per neuron.
package df_stream_pkg;

  localparam int WORD_DATA_W = 16;
  localparam int FRAC_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } df_state_e;

  function automatic int stride(input int n_in);
`ifdef DF_BIAS_FETCH_EN
    return n_in + 1;
`else
    return n_in;
`endif
  endfunction

endpackage

// File: rtl/df_skid.sv
// Two-entry valid/ready skid FIFO that absorbs downstream backpressure.
// The caller never pushes into a full buffer; occ exposes the fill level.
module df_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_data,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop;

  assign pop_vld  = (occ != 2'd0);
  assign pop      = pop_vld && pop_rdy;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage itself is reset because the head entry drives the
      // block outputs directly, and those must read zero during reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/df_stream.sv
// Data-fetch stage: snapshots N_IN inputs per start and streams (weight, input)
// pairs with valid/ready, last and done framing. DF_BIAS_FETCH_EN appends a bias pair.
module df_stream
  import df_stream_pkg::*;
#(
  parameter int DATA_W = WORD_DATA_W,
  parameter int N_IN   = 7,
  parameter int N_NEU  = 4,
  parameter int ADDR_W = 8,
  parameter int FRAC_W = FRAC_W_DEF,
  localparam int NSEL_W = (N_NEU > 1) ? $clog2(N_NEU) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_rdy,
  input  logic [NSEL_W-1:0]      neu_sel,
  input  logic [N_IN*DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0]      wram_addr,
  output logic                   wram_rd_en,
  input  logic [DATA_W-1:0]      wram_rdata,
  output logic [DATA_W-1:0]      data_w,
  output logic [DATA_W-1:0]      data_i,
  output logic                   df_vld,
  input  logic                   df_rdy,
  output logic                   df_last,
  output logic                   busy,
  output logic                   done
);

  localparam int STRIDE = stride(N_IN);
  localparam int IDX_W  = $clog2(STRIDE + 1);
  localparam int SKID_W = 2 * DATA_W + 1;
  localparam logic [DATA_W-1:0] BIAS_ONE = DATA_W'(1) << FRAC_W;

  df_state_e                state;
  logic [N_IN*DATA_W-1:0]   snap;
  logic [ADDR_W-1:0]        base;
  logic [IDX_W-1:0]         idx;
  logic                     inflight;
  logic                     tag_last;
  logic [DATA_W-1:0]        tag_i;
  logic [DATA_W-1:0]        cur_i;
  logic [NSEL_W-1:0]        neu_c;
  logic [1:0]               occ;
  logic [SKID_W-1:0]        head;
  logic                     pop;
  logic                     issue;
  logic                     is_last_idx;

  assign pop         = df_vld && df_rdy;
  assign is_last_idx = (idx == IDX_W'(STRIDE - 1));
  // Count the entry leaving this cycle as free so a steady stream issues every cycle.
  assign issue       = (state == ST_FETCH) && ((occ + {1'b0, inflight} - {1'b0, pop}) < 2'd2);
  assign wram_rd_en  = issue;
  assign wram_addr   = issue ? (base + ADDR_W'(idx)) : '0;
  assign neu_c       = (neu_sel > NSEL_W'(N_NEU - 1)) ? NSEL_W'(N_NEU - 1) : neu_sel;

  // Index N_IN only exists with the bias word and selects fixed-point 1.0.
  always_comb begin
    // NOTE: default first so every path assigns cur_i and no latch is inferred.
    cur_i = BIAS_ONE;
    for (int k = 0; k < N_IN; k++)
      if (idx == IDX_W'(k)) cur_i = snap[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      snap     <= '0;
      base     <= '0;
      idx      <= '0;
      inflight <= 1'b0;
      tag_last <= 1'b0;
      tag_i    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        tag_i    <= cur_i;
        tag_last <= is_last_idx;
      end
      case (state)
        ST_IDLE: begin
          if (in_rdy) begin
            snap  <= data_in;
            base  <= ADDR_W'(neu_c) * ADDR_W'(STRIDE);
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            idx <= idx + IDX_W'(1);
            if (is_last_idx) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && df_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  df_skid #(.W(SKID_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data ({tag_last, wram_rdata, tag_i}),
    .pop_rdy   (df_rdy),
    .pop_vld   (df_vld),
    .pop_data  (head),
    .occ       (occ)
  );

  assign {df_last, data_w, data_i} = head;

endmodule

// File: tb/tb_df_stream.sv
// Self-checking bench for df_stream: a queue-based reference model of the
// expected pair stream and address sequence, with randomized backpressure.
module tb_df_stream;

  localparam int DATA_W = 16;
  localparam int N_IN   = 7;
  localparam int N_NEU  = 4;
  localparam int ADDR_W = 8;
  localparam int FRAC_W = 8;
`ifdef DF_BIAS_FETCH_EN
  localparam int CNT = N_IN + 1;
`else
  localparam int CNT = N_IN;
`endif

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] i;
  } pair_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   in_rdy = 1'b0;
  logic [1:0]             neu_sel = '0;
  logic [N_IN*DATA_W-1:0] data_in = '0;
  logic [ADDR_W-1:0]      wram_addr;
  logic                   wram_rd_en;
  logic [DATA_W-1:0]      wram_rdata = '0;
  logic [DATA_W-1:0]      data_w;
  logic [DATA_W-1:0]      data_i;
  logic                   df_vld;
  logic                   df_rdy = 1'b1;
  logic                   df_last;
  logic                   busy;
  logic                   done;

  // Second instance with a non-power-of-two neuron count to exercise clamping.
  logic                   in_rdy3 = 1'b0;
  logic [1:0]             neu_sel3 = '0;
  logic [ADDR_W-1:0]      wram_addr3;
  logic                   wram_rd_en3;
  logic [DATA_W-1:0]      wram_rdata3 = '0;
  logic [DATA_W-1:0]      data_w3;
  logic [DATA_W-1:0]      data_i3;
  logic                   df_vld3;
  logic                   df_rdy3 = 1'b1;
  logic                   df_last3;
  logic                   busy3;
  logic                   done3;

  logic [DATA_W-1:0] ram [256];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    rdy_mode = 0;
  int    pat = 0;
  int    t_start = 0;

  pair_t             got_q[$];
  pair_t             exp_q[$];
  int                pop_cyc_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [ADDR_W-1:0] addr3_q[$];
  int    rd_cnt, done_cnt, done_cyc, done3_cnt, stall_viol;
  logic  prev_stall = 1'b0;
  pair_t prev_head, cur_head;

  df_stream #(.DATA_W(DATA_W), .N_IN(N_IN), .N_NEU(N_NEU), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W)) u_dut (
    .clk(clk), .reset(reset), .in_rdy(in_rdy), .neu_sel(neu_sel), .data_in(data_in),
    .wram_addr(wram_addr), .wram_rd_en(wram_rd_en), .wram_rdata(wram_rdata),
    .data_w(data_w), .data_i(data_i), .df_vld(df_vld), .df_rdy(df_rdy),
    .df_last(df_last), .busy(busy), .done(done)
  );

  df_stream #(.DATA_W(DATA_W), .N_IN(N_IN), .N_NEU(3), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W)) u_dut3 (
    .clk(clk), .reset(reset), .in_rdy(in_rdy3), .neu_sel(neu_sel3), .data_in(data_in),
    .wram_addr(wram_addr3), .wram_rd_en(wram_rd_en3), .wram_rdata(wram_rdata3),
    .data_w(data_w3), .data_i(data_i3), .df_vld(df_vld3), .df_rdy(df_rdy3),
    .df_last(df_last3), .busy(busy3), .done(done3)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (wram_rd_en)  wram_rdata  <= ram[wram_addr];
    if (wram_rd_en3) wram_rdata3 <= ram[wram_addr3];
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       df_rdy = 1'b1;
      1:       df_rdy = (pat % 3 == 0);
      default: df_rdy = 1'($urandom_range(0, 1));
    endcase
    pat++;
  end

  always @(negedge clk) begin
    if (reset) begin
      cur_head = {df_last, data_w, data_i};
      if (df_vld && df_rdy) begin
        got_q.push_back(cur_head);
        pop_cyc_q.push_back(cyc);
      end
      if (wram_rd_en) begin
        addr_q.push_back(wram_addr);
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_stall && (!df_vld || cur_head !== prev_head)) stall_viol++;
      prev_stall = df_vld && !df_rdy;
      prev_head  = cur_head;
      if (wram_rd_en3) addr3_q.push_back(wram_addr3);
      if (done3) done3_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N_IN*DATA_W-1:0] seq_din(input int first);
    logic [N_IN*DATA_W-1:0] d;
    for (int k = 0; k < N_IN; k++) d[k*DATA_W +: DATA_W] = DATA_W'(first + k);
    return d;
  endfunction

  function automatic logic [N_IN*DATA_W-1:0] rand_din();
    logic [N_IN*DATA_W-1:0] d;
    for (int k = 0; k < N_IN; k++) d[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    return d;
  endfunction

  // Expected stream: element k reads RAM[n*CNT+k]; inputs follow, then 1.0 for bias.
  task automatic build_exp(input int sel, input int n_neu, input logic [N_IN*DATA_W-1:0] din);
    int    n;
    int    a;
    pair_t p;
    n = (sel > n_neu - 1) ? n_neu - 1 : sel;
    exp_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < CNT; k++) begin
      a = (n * CNT + k) % 256;
      exp_addr_q.push_back(ADDR_W'(a));
      p.w    = ram[a];
      p.i    = (k < N_IN) ? din[k*DATA_W +: DATA_W] : DATA_W'(1 << FRAC_W);
      p.last = (k == CNT - 1);
      exp_q.push_back(p);
    end
  endtask

  function automatic int stream_errs();
    int e;
    e = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    e += (addr_q.size() != exp_addr_q.size()) ? 1 : 0;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] !== exp_q[k]) e++;
    for (int k = 0; k < addr_q.size() && k < exp_addr_q.size(); k++)
      if (addr_q[k] !== exp_addr_q[k]) e++;
    return e;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    pop_cyc_q.delete();
    addr_q.delete();
    addr3_q.delete();
    rd_cnt = 0;
    done_cnt = 0;
    done3_cnt = 0;
    done_cyc = -1;
    stall_viol = 0;
  endtask

  task automatic init_ram();
    for (int a = 0; a < 256; a++) ram[a] = DATA_W'(a + 100);
  endtask

  task automatic start(input logic [1:0] sel, input logic [N_IN*DATA_W-1:0] din);
    @(posedge clk);
    #1;
    neu_sel = sel;
    data_in = din;
    in_rdy  = 1'b1;
    @(posedge clk);
    #1;
    t_start = cyc;
    in_rdy  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    reset = 1'b0;
    #3;
    outs = 64'({wram_addr, wram_rd_en, data_w, data_i, df_vld, df_last, busy, done});
    checks++;
    if (outs !== 64'd0) $display("FAIL reset_outputs: got %h, need 0", outs);
    if (outs !== 64'd0) errors++;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, df_vld, wram_rd_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: busy/vld/rd_en=%b, need 000", {busy, df_vld, wram_rd_en});
    end
  endtask

  task automatic test_default();
    logic ok;
    int   e;
    rdy_mode = 0;
    init_ram();
    clear_mon();
    build_exp(2, N_NEU, seq_din(1));
    start(2'd2, seq_din(1));
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL default_busy: got %b, need 1", busy); end
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL default_done_timeout: got no done, need done"); end
    e = stream_errs();
    checks++;
    if (e !== 0) begin errors++; $display("FAIL default_stream: bad=%0d, need 0", e); end
    checks++;
    if (pop_cyc_q.size() != CNT || pop_cyc_q[0] !== t_start + 2 || pop_cyc_q[CNT-1] !== t_start + CNT + 1) begin
      errors++;
      $display("FAIL default_timing: first=%0d last=%0d, need %0d %0d",
               pop_cyc_q[0] - t_start, pop_cyc_q[pop_cyc_q.size()-1] - t_start, 2, CNT + 1);
    end
    checks++;
    if (done_cyc !== t_start + CNT + 2) begin
      errors++;
      $display("FAIL default_done_cycle: got t+%0d, need t+%0d", done_cyc - t_start, CNT + 2);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL default_done_pulse: count=%0d busy=%b, need 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    int   e;
    rdy_mode = 1;
    pat = 0;
    clear_mon();
    build_exp(2, N_NEU, seq_din(1));
    start(2'd2, seq_din(1));
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_done_timeout: got no done, need done"); end
    e = stream_errs();
    checks++;
    if (e !== 0) begin errors++; $display("FAIL bp_stream: bad=%0d, need 0", e); end
    checks++;
    if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable: violations=%0d, need 0", stall_viol); end
    checks++;
    if (rd_cnt !== CNT) begin errors++; $display("FAIL bp_rd_count: got %0d, need %0d", rd_cnt, CNT); end
    rdy_mode = 0;
  endtask

  task automatic test_busy_snapshot();
    logic ok;
    int   e;
    rdy_mode = 1;
    pat = 0;
    clear_mon();
    build_exp(1, N_NEU, seq_din(40));
    start(2'd1, seq_din(40));
    repeat (3) @(posedge clk);
    #1;
    in_rdy  = 1'b1;
    neu_sel = 2'd3;
    data_in = seq_din(900);
    @(posedge clk);
    #1;
    in_rdy = 1'b0;
    wait_done(400, ok);
    repeat (20) @(negedge clk);
    #1;
    e = stream_errs();
    checks++;
    if (e !== 0) begin errors++; $display("FAIL snapshot_stream: bad=%0d, need 0", e); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL busy_single_done: got %0d, need 1", done_cnt); end
    checks++;
    if (rd_cnt !== CNT || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignored: reads=%0d busy=%b, need %0d 0", rd_cnt, busy, CNT);
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    logic        ok;
    int          n;
    int          e;
    logic [63:0] outs;
    rdy_mode = 0;
    clear_mon();
    start(2'd0, seq_din(7));
    n = 0;
    while (got_q.size() < 3 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    #1 reset = 1'b0;
    #1;
    outs = 64'({wram_addr, wram_rd_en, data_w, data_i, df_vld, df_last, busy, done});
    checks++;
    if (got_q.size() != 3 || outs !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: pairs=%0d outs=%h, need 3 0", got_q.size(), outs);
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d, need 0", done_cnt); end
    clear_mon();
    build_exp(1, N_NEU, seq_din(50));
    start(2'd1, seq_din(50));
    wait_done(200, ok);
    e = stream_errs();
    checks++;
    if (!ok || e !== 0) begin errors++; $display("FAIL mid_reset_restart: done=%b bad=%0d, need 1 0", ok, e); end
  endtask

  task automatic test_clamp();
    logic ok;
    int   e;
    int   n3;
    int   sel;
    rdy_mode = 0;
    clear_mon();
    build_exp(3, N_NEU, seq_din(1));
    start(2'd3, seq_din(1));
    wait_done(200, ok);
    e = stream_errs();
    checks++;
    if (!ok || e !== 0) begin errors++; $display("FAIL clamp_top_neuron: done=%b bad=%0d, need 1 0", ok, e); end
    for (int r = 0; r < 2; r++) begin
      clear_mon();
      sel = 3 - r;
      n3 = (sel > 2) ? 2 : sel;
      @(posedge clk);
      #1;
      neu_sel3 = 2'(sel);
      in_rdy3  = 1'b1;
      @(posedge clk);
      #1;
      in_rdy3 = 1'b0;
      repeat (CNT + 6) @(negedge clk);
      #1;
      e = (addr3_q.size() != CNT) ? 1 : 0;
      for (int k = 0; k < addr3_q.size(); k++)
        if (addr3_q[k] !== ADDR_W'(n3 * CNT + k)) e++;
      checks++;
      if (e !== 0 || done3_cnt !== 1) begin
        errors++;
        $display("FAIL clamp_sel%0d: bad=%0d done=%0d, need 0 1", sel, e, done3_cnt);
      end
    end
  endtask

`ifdef DF_BIAS_FETCH_EN
  task automatic test_bias();
    logic  ok;
    pair_t p7;
    init_ram();
    rdy_mode = 0;
    clear_mon();
    start(2'd1, seq_din(1));
    wait_done(200, ok);
    p7 = got_q[7];
    checks++;
    if (!ok || got_q.size() != 8 || p7 !== {1'b1, 16'd115, 16'd256}) begin
      errors++;
      $display("FAIL bias_pair: pairs=%0d last=%h, need 8 %h", got_q.size(), p7, {1'b1, 16'd115, 16'd256});
    end
    checks++;
    if (got_q[6].last !== 1'b0 || addr_q[0] !== 8'd8 || addr_q[7] !== 8'd15) begin
      errors++;
      $display("FAIL bias_addr_last: last6=%b a0=%0d a7=%0d, need 0 8 15", got_q[6].last, addr_q[0], addr_q[7]);
    end
  endtask
`endif

  task automatic test_random();
    logic                   ok;
    int                     e;
    logic [1:0]             sel;
    logic [N_IN*DATA_W-1:0] din;
    rdy_mode = 2;
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 256; a++) ram[a] = DATA_W'($urandom);
      sel = 2'($urandom_range(0, 3));
      din = rand_din();
      clear_mon();
      build_exp(int'(sel), N_NEU, din);
      start(sel, din);
      wait_done(500, ok);
      e = stream_errs();
      checks++;
      if (!ok || e !== 0 || stall_viol !== 0) begin
        errors++;
        $display("FAIL random_run%0d: done=%b bad=%0d stall=%0d, need 1 0 0", r, ok, e, stall_viol);
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    init_ram();
    test_reset();
    test_default();
    test_backpressure();
    test_busy_snapshot();
    test_reset_mid();
    test_clamp();
`ifdef DF_BIAS_FETCH_EN
    test_bias();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
